// File: rtl/mem_if_pkg.sv
// Shared data-memory interface types.
// Used by the responder and the CPU-side initiator.
package mem_if_pkg;

   localparam int WORD_W = 32;
   localparam int STRB_W = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } rsp_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with byte-lane writes.
// Read is combinational so the FSM can capture at acceptance.
module dmem_array
   import mem_if_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed latency.
// Stores commit and loads sample at the acceptance edge.
module dmem_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   rsp_state_e        state;
   logic [3:0]        cnt;
   logic [AW-1:0]     idx;
   logic              addr_err;
   logic              accept;
   logic              mem_we;
   logic [WORD_W-1:0] mem_rdata;

   assign idx      = req_addr[AW+1:2];
   assign addr_err = (req_addr[1:0] != 2'b00) ||
                     ((req_addr >> (AW + 2)) != 32'd0);
   assign accept   = req_valid & req_ready;
   assign mem_we   = accept & req_we & ~addr_err;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .idx   (idx),
      .wdata (req_wdata),
      .wstrb (req_wstrb),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  rsp_err   <= addr_err;
                  rsp_rdata <= (addr_err || req_we) ?
                               '0 : mem_rdata;
                  if (LATENCY > 1) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state     <= RESP;
                  cnt       <= 4'd0;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               // Ready stays low this edge; next accept is a cycle later.
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Main instance LATENCY=2, second instance LATENCY=1.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        req_valid1;
   logic        req_ready1;
   logic        rsp_valid1;
   logic [31:0] rsp_rdata1;
   logic        rsp_err1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] ref_mem [DEPTH];

   dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY(LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   dmem_responder #(
      .DEPTH_WORDS(16),
      .LATENCY(1)
   ) dut1 (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid1),
      .req_ready (req_ready1),
      .req_we    (1'b0),
      .req_addr  (32'h4),
      .req_wdata (32'h0),
      .req_wstrb (4'h0),
      .rsp_valid (rsp_valid1),
      .rsp_ready (1'b1),
      .rsp_rdata (rsp_rdata1),
      .rsp_err   (rsp_err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
   endfunction

   task automatic model(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
      exp_t e;
      int   w;
      w = int'(a[31:2]);
      if (is_err(a)) begin
         e.rdata = 32'h0;
         e.err   = 1'b1;
      end else if (we) begin
         for (int i = 0; i < 4; i++)
            if (st[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
         e.rdata = 32'h0;
         e.err   = 1'b0;
      end else begin
         e.rdata = ref_mem[w];
         e.err   = 1'b0;
      end
      sb.push_back(e);
   endtask

   task automatic send(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
      @(negedge clk);
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      req_wstrb = st;
      req_valid = 1'b1;
      check("req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      model(we, a, wd, st);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic expect_rsp(input string tag);
      int   n;
      bit   seen;
      exp_t e;
      n    = 0;
      seen = 1'b0;
      while (n < 20 && !seen) begin
         @(negedge clk);
         n++;
         seen = rsp_valid;
      end
      check({tag, "_lat"}, 32'(n), 32'(LAT));
      check({tag, "_sbq"}, 32'(sb.size()), 32'd1);
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_rdata"}, rsp_rdata, e.rdata);
         check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      end
      if (rsp_ready) begin
         @(negedge clk);
         check({tag, "_1cyc"}, 32'(rsp_valid), 32'd0);
         check({tag, "_idle"}, 32'(req_ready), 32'd1);
      end
   endtask

   function automatic int mem_diffs();
      int d;
      d = 0;
      for (int i = 0; i < DEPTH; i++)
         if (dut.u_array.mem[i] !== ref_mem[i]) d++;
      return d;
   endfunction

   initial begin
      logic [31:0] held;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_valid1 = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_wstrb  = 4'h0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = 32'h5A000000 | 32'(i);
      end
      ref_mem[0] = 32'h0000000A;
      ref_mem[2] = 32'h11223344;
      for (int i = 0; i < DEPTH; i++) begin
         dut.u_array.mem[i] = ref_mem[i];
      end
      dut1.u_array.mem[1] = 32'h00000055;

      #12;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // First request in the first cycle with reset low.
      req_addr  = 32'h0;
      req_valid = 1'b1;
      check("req_ready0", 32'(req_ready), 32'd1);
      @(posedge clk);
      model(1'b0, 32'h0, 32'h0, 4'h0);
      #1 req_valid = 1'b0;
      expect_rsp("ld0");

      send(1'b1, 32'h4, 32'h00000006, 4'hF);
      expect_rsp("st4");
      send(1'b0, 32'h4, 32'h0, 4'h0);
      expect_rsp("ld4");

      send(1'b1, 32'h8, 32'hAABBCCDD, 4'h5);
      expect_rsp("st8");
      send(1'b0, 32'h8, 32'h0, 4'h0);
      expect_rsp("ld8");
      check("ld8_val", ref_mem[2], 32'h11BB33DD);

      send(1'b1, 32'h8, 32'hFFFFFFFF, 4'h0);
      expect_rsp("st8_nostrb");
      send(1'b0, 32'h8, 32'h0, 4'h0);
      expect_rsp("ld8_again");

      send(1'b0, 32'h6, 32'h0, 4'h0);
      expect_rsp("ld_mis");
      send(1'b0, 32'h400, 32'h0, 4'h0);
      expect_rsp("ld_oob");
      send(1'b1, 32'h400, 32'hDEADBEEF, 4'hF);
      expect_rsp("st_oob");
      check("mem_scan_oob", 32'(mem_diffs()), 32'd0);

      // Stall the response while a store is pressing.
      rsp_ready = 1'b0;
      send(1'b0, 32'h10, 32'h0, 4'h0);
      expect_rsp("ld_stall");
      req_we    = 1'b1;
      req_addr  = 32'hC;
      req_wdata = 32'hDEAD0000;
      req_wstrb = 4'hF;
      req_valid = 1'b1;
      held      = ref_mem[4];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_rdata", rsp_rdata, held);
         check("stall_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("stall_done", 32'(rsp_valid), 32'd0);
      check("stall_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      req_we    = 1'b0;
      send(1'b0, 32'hC, 32'h0, 4'h0);
      expect_rsp("ld_c");

      // Reset while a load is in WAIT.
      send(1'b0, 32'h14, 32'h0, 4'h0);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("wrst_valid", 32'(rsp_valid), 32'd0);
      check("wrst_ready", 32'(req_ready), 32'd1);
      check("wrst_rdata", rsp_rdata, 32'h0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("wrst_drop", 32'(rsp_valid), 32'd0);
      end
      check("mem_scan_rst", 32'(mem_diffs()), 32'd0);

      // LATENCY=1 instance.
      @(negedge clk);
      req_valid1 = 1'b1;
      check("l1_ready", 32'(req_ready1), 32'd1);
      @(posedge clk);
      #1 req_valid1 = 1'b0;
      @(negedge clk);
      check("l1_valid", 32'(rsp_valid1), 32'd1);
      check("l1_rdata", rsp_rdata1, 32'h00000055);
      check("l1_err", 32'(rsp_err1), 32'd0);
      @(negedge clk);
      check("l1_1cyc", 32'(rsp_valid1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
